// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch buffer: FSM encoding,
// buffer depth and the canonical NOP encoding.
package ifetch_pkg;

  localparam int          FIFO_DEPTH = 2;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, inst} FIFO with synchronous clear; head reads as zero when empty.
module fetch_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] push_pc,
  input  logic [W-1:0] push_inst,
  output logic [W-1:0] head_pc,
  output logic [W-1:0] head_inst,
  output logic [1:0]   count
);

  logic [W-1:0] pc_mem_r   [2];
  logic [W-1:0] inst_mem_r [2];
  logic         rd_ptr_r;
  logic         wr_ptr_r;
  logic [1:0]   count_r;

  // Storage, pointers and occupancy; clear dominates any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        pc_mem_r[i]   <= '0;
        inst_mem_r[i] <= '0;
      end
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (clear) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push) begin
        pc_mem_r[wr_ptr_r]   <= push_pc;
        inst_mem_r[wr_ptr_r] <= push_inst;
        wr_ptr_r             <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Head view, forced to zero while the buffer is empty.
  always_comb begin
    if (count_r != 2'd0) begin
      head_pc   = pc_mem_r[rd_ptr_r];
      head_inst = inst_mem_r[rd_ptr_r];
    end else begin
      head_pc   = '0;
      head_inst = '0;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction fetch front end: one outstanding memory read at a time, results
// queued in a 2-entry buffer, with flush-driven discard of stale responses.
module ifetch_buffer
  import ifetch_pkg::*;
#(
  parameter int WORD_BITWIDTH = 32,
  parameter int FIFO_DEPTH    = ifetch_pkg::FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WORD_BITWIDTH-1:0] pc,
  input  logic                     pc_valid,
  output logic                     pc_ready,
  input  logic                     flush,
  output logic                     imem_req,
  output logic [WORD_BITWIDTH-1:0] imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [WORD_BITWIDTH-1:0] imem_rdata,
  output logic                     inst_valid,
  output logic [WORD_BITWIDTH-1:0] inst,
  output logic [WORD_BITWIDTH-1:0] inst_pc,
  input  logic                     inst_ready
);

  localparam logic [1:0] DEPTH_C = 2'(FIFO_DEPTH);

  fetch_state_e             state_r;
  fetch_state_e             next_state_s;
  logic                     kill_r;
  logic [WORD_BITWIDTH-1:0] addr_r;
  logic                     imem_req_r;
  logic [1:0]               count_s;
  logic                     accept_s;
  logic                     push_s;
  logic                     pop_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state; a pending request is held until granted even across a flush.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: if (accept_s)    next_state_s = ST_REQ;  else next_state_s = ST_IDLE;
      ST_REQ:  if (imem_gnt)    next_state_s = ST_WAIT; else next_state_s = ST_REQ;
      ST_WAIT: if (imem_rvalid) next_state_s = ST_IDLE; else next_state_s = ST_WAIT;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Handshake decode; the credit check on count keeps push from ever hitting a full buffer.
  always_comb begin
    pc_ready = (state_r == ST_IDLE) && !flush && (count_s < DEPTH_C);
    accept_s = pc_valid && pc_ready;
    push_s   = (state_r == ST_WAIT) && imem_rvalid && !kill_r && !flush;
    pop_s    = inst_valid && inst_ready;
  end

  // Kill marks the in-flight fetch as stale; it lives until that response returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill_r <= 1'b0;
    end else if ((state_r == ST_WAIT) && imem_rvalid) begin
      kill_r <= 1'b0;
    end else if (flush && (state_r != ST_IDLE)) begin
      kill_r <= 1'b1;
    end else begin
      kill_r <= kill_r;
    end
  end

  // Fetch address and registered memory request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r     <= '0;
      imem_req_r <= 1'b0;
    end else begin
      if (accept_s) begin
        addr_r <= pc;
      end
      imem_req_r <= (next_state_s == ST_REQ);
    end
  end

  assign imem_req   = imem_req_r;
  assign imem_addr  = addr_r;
  assign inst_valid = (count_s != 2'd0);

  fetch_fifo #(
    .W(WORD_BITWIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .pop       (pop_s),
    .clear     (flush),
    .push_pc   (addr_r),
    .push_inst (imem_rdata),
    .head_pc   (inst_pc),
    .head_inst (inst),
    .count     (count_s)
  );

endmodule

// File: tb/tb_ifetch_buffer.sv
// Self-checking bench for ifetch_buffer: constant vector table, directed corner
// sequences and a random phase compared against a queue-based reference model.
module tb_ifetch_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = 32'd0;
  logic        pc_valid = 1'b0;
  logic        pc_ready;
  logic        flush = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  ifetch_buffer #(.WORD_BITWIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        m_q[$];
  logic        m_busy, m_granted, m_killed;
  logic [31:0] m_pend;
  logic        last_acc, last_ready;

  typedef struct {
    logic pv; logic [31:0] pc; logic g; logic rv; logic [31:0] rd; logic ir;
    logic exp_ready; logic exp_req; logic exp_iv; logic [31:0] exp_inst; logic [31:0] exp_pc;
  } vec_t;
  vec_t vt[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_busy = 1'b0; m_granted = 1'b0; m_killed = 1'b0; m_pend = 32'd0;
  endtask

  // One clock: drive inputs after the falling edge, check, update model at the rising edge.
  task automatic step(input logic pv, input logic [31:0] pcv, input logic fl, input logic g,
                      input logic rv, input logic [31:0] rd, input logic ir);
    logic exp_ready, acc, pop, resp;
    ent_t e;
    pc_valid = pv; pc = pcv; flush = fl; imem_gnt = g;
    imem_rvalid = rv; imem_rdata = rd; inst_ready = ir;
    exp_ready = !m_busy && !fl && (m_q.size() < 2);
    #1;
    last_ready = pc_ready;
    chk("pc_ready", {31'd0, pc_ready}, {31'd0, exp_ready});
    acc  = pv && exp_ready;
    pop  = (m_q.size() != 0) && ir;
    resp = m_busy && m_granted && rv;
    @(posedge clk);
    if (fl) begin
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (resp && !m_killed) begin
        e.pc = m_pend; e.inst = rd;
        m_q.push_back(e);
      end
    end
    if (resp) m_killed = 1'b0;
    else if (fl && m_busy) m_killed = 1'b1;
    if (resp) begin
      m_busy = 1'b0; m_granted = 1'b0;
    end else if (m_busy && !m_granted && g) begin
      m_granted = 1'b1;
    end
    if (acc) begin
      m_busy = 1'b1; m_granted = 1'b0; m_pend = pcv;
    end
    last_acc = acc;
    @(negedge clk);
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_busy && !m_granted});
    if (m_busy && !m_granted) chk("imem_addr", imem_addr, m_pend);
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_q.size() != 0});
    chk("inst", inst, (m_q.size() != 0) ? m_q[0].inst : 32'd0);
    chk("inst_pc", inst_pc, (m_q.size() != 0) ? m_q[0].pc : 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'd0);
    chk({tag, "_iv"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, "_inst"}, inst, 32'd0);
    chk({tag, "_ipc"}, inst_pc, 32'd0);
  endtask

  task automatic do_reset();
    pc_valid = 1'b0; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("reset");
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int gd,
                       input int rdl, input logic ir);
    int n = 0;
    last_acc = 1'b0;
    while (!last_acc && n < 20) begin
      step(1'b1, a, 1'b0, 1'b0, 1'b0, 32'd0, ir);
      n++;
    end
    chk("fetch_accept", {31'd0, last_acc}, 32'd1);
    repeat (gd) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, ir);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, ir);
    repeat (rdl) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, ir);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, d, ir);
  endtask

  task automatic drain();
    repeat (3) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
  endtask

  initial begin
    //        pv    pc     g     rv    rdata          ir    rdy   req   iv    inst           ipc
    vt[0] = '{1'b1, 32'd0, 1'b0, 1'b0, 32'd0,        1'b0, 1'b1, 1'b1, 1'b0, 32'd0,        32'd0};
    vt[1] = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        32'd0};
    vt[2] = '{1'b0, 32'd0, 1'b0, 1'b1, 32'h00500093, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00500093, 32'd0};
    vt[3] = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0,        1'b1, 1'b1, 1'b0, 1'b0, 32'd0,        32'd0};

    do_reset();
    // Minimum-latency single fetch.
    for (int i = 0; i < 4; i++) begin
      step(vt[i].pv, vt[i].pc, 1'b0, vt[i].g, vt[i].rv, vt[i].rd, vt[i].ir);
      chk($sformatf("tbl%0d_ready", i), {31'd0, last_ready}, {31'd0, vt[i].exp_ready});
      chk($sformatf("tbl%0d_req", i), {31'd0, imem_req}, {31'd0, vt[i].exp_req});
      chk($sformatf("tbl%0d_iv", i), {31'd0, inst_valid}, {31'd0, vt[i].exp_iv});
      chk($sformatf("tbl%0d_inst", i), inst, vt[i].exp_inst);
      chk($sformatf("tbl%0d_ipc", i), inst_pc, vt[i].exp_pc);
    end

    // Buffer fills, third fetch is held off until a pop, order preserved.
    fetch(32'd0, 32'h1111_0000, 0, 0, 1'b0);
    fetch(32'd4, 32'h1111_0004, 0, 0, 1'b0);
    repeat (3) step(1'b1, 32'd8, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("full_ready", {31'd0, last_ready}, 32'd0);
    step(1'b1, 32'd8, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("order_second", inst_pc, 32'd4);
    fetch(32'd8, 32'h1111_0008, 0, 0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("order_third", inst_pc, 32'd8);
    drain();

    // Flush while waiting for data: the response is dropped.
    step(1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    chk("killed_resp_iv", {31'd0, inst_valid}, 32'd0);
    fetch(32'h40, 32'h0000_0040, 0, 0, 1'b0);
    chk("redirect_pc", inst_pc, 32'h40);
    drain();

    // Flush during a slow grant: request held stable, response dropped, kill cleared.
    step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("held_addr", imem_addr, 32'h100);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("held_req", {31'd0, imem_req}, 32'd1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'hBAD0_0100, 1'b0);
    chk("slow_gnt_drop", {31'd0, inst_valid}, 32'd0);
    fetch(32'h104, 32'hC0DE_0104, 1, 1, 1'b0);
    chk("after_kill_pc", inst_pc, 32'h104);
    drain();

    // Full buffer hit by flush, pop and a stray rvalid together.
    fetch(32'h10, 32'hA0, 0, 0, 1'b0);
    fetch(32'h14, 32'hA4, 0, 0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
    chk("full_flush_iv", {31'd0, inst_valid}, 32'd0);
    // Same mix while a response really completes.
    fetch(32'h20, 32'hB0, 0, 0, 1'b0);
    step(1'b1, 32'h24, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'hB4, 1'b1);
    chk("flush_rvalid_iv", {31'd0, inst_valid}, 32'd0);
    fetch(32'h30, 32'hC0, 0, 0, 1'b0);
    chk("flush_rvalid_next", inst_pc, 32'h30);
    drain();

    // Asynchronous reset while waiting for data, then a stray response.
    fetch(32'h50, 32'hD0, 0, 0, 1'b0);
    step(1'b1, 32'h54, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("pre_reset_iv", {31'd0, inst_valid}, 32'd1);
    do_reset();
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'hEEEE_0054, 1'b0);
    chk("stray_rvalid_iv", {31'd0, inst_valid}, 32'd0);

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      logic rv;
      rv = m_granted ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
      step(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
           rv, $urandom, 1'($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
